// File: rtl/plot_pkg.sv
// Shared types and constants for the sprite pixel plotter.
// Also holds the coordinate-to-address helper.
package plot_pkg;
    localparam int DEF_WIDTH  = 640;
    localparam int DEF_HEIGHT = 480;
    localparam int ADDR_W     = 19;
    localparam int COORD_W    = 11;

    typedef enum logic [1:0] {IDLE, FLUSH, CLEAR} plot_state_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               color;
    } point_t;

    // y*width + x in ADDR_W bits; the 640-wide case avoids a multiplier.
    function automatic logic [ADDR_W-1:0] pix_addr(input logic [COORD_W-1:0] x,
                                                   input logic [COORD_W-1:0] y,
                                                   input int unsigned width);
        logic [ADDR_W-1:0] yy;
        yy = ADDR_W'(y);
        if (width == 640)
            return (yy << 9) + (yy << 7) + ADDR_W'(x);
        return ADDR_W'(yy * ADDR_W'(width)) + ADDR_W'(x);
    endfunction
endpackage

// File: rtl/framebuffer_plotter_if.sv
// Point stream from a drawer plus the 1-bpp framebuffer write port.
interface framebuffer_plotter_if;
    import plot_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [COORD_W-1:0] in_x;
    logic [COORD_W-1:0] in_y;
    logic               in_color;
    logic               fb_we;
    logic               fb_ready;
    logic [ADDR_W-1:0]  fb_addr;
    logic               fb_data;

    modport slave (
        input  in_valid, in_x, in_y, in_color, fb_ready,
        output in_ready, fb_we, fb_addr, fb_data
    );

    modport master (
        output in_valid, in_x, in_y, in_color, fb_ready,
        input  in_ready, fb_we, fb_addr, fb_data
    );
endinterface

// File: rtl/plot_fifo.sv
// Synchronous point FIFO; pointers carry an extra wrap bit to tell full from empty.
module plot_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 23
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout    = mem[rd_ptr[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/framebuffer_plotter.sv
// Clips and queues drawer points, emits one framebuffer write per point,
// and runs the whole-screen clear sweep once queued points have drained.
module framebuffer_plotter
    import plot_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT,
    parameter int DEPTH  = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    framebuffer_plotter_if.slave        bus,
    input  logic                        clear_start,
    output logic                        clear_done,
    output logic                        busy,
    output logic [7:0]                  clip_count
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH*HEIGHT - 1);

    plot_state_t       state;
    point_t            in_pt;
    point_t            head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              accept;
    logic              clipped;
    logic              grant;
    logic              load;
    logic              fb_we_r;
    logic [ADDR_W-1:0] fb_addr_r;
    logic              fb_data_r;

    assign in_pt   = '{x: bus.in_x, y: bus.in_y, color: bus.in_color};
    assign bus.in_ready = (state == IDLE) && !fifo_full && !reset;
    assign accept  = bus.in_valid && bus.in_ready;
    assign clipped = (int'(bus.in_x) >= WIDTH) || (int'(bus.in_y) >= HEIGHT);
    assign grant   = fb_we_r && bus.fb_ready;
    // Refill the output register whenever it is free or being emptied this cycle.
    assign load    = (state != CLEAR) && !fifo_empty && (!fb_we_r || grant);

    assign bus.fb_we   = fb_we_r;
    assign bus.fb_addr = fb_addr_r;
    assign bus.fb_data = fb_data_r;

    assign clear_done = !reset && (state == CLEAR) && grant && (fb_addr_r == LAST_ADDR);
    assign busy       = (state != IDLE) || !fifo_empty || fb_we_r;

    plot_fifo #(.DEPTH(DEPTH), .W($bits(point_t))) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept && !clipped),
        .pop   (load),
        .din   (in_pt),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            fb_we_r    <= 1'b0;
            fb_addr_r  <= '0;
            fb_data_r  <= 1'b0;
            clip_count <= '0;
        end else begin
            if (accept && clipped && clip_count != 8'hFF)
                clip_count <= clip_count + 8'd1;

            case (state)
                IDLE, FLUSH: begin
                    if (load) begin
                        fb_we_r   <= 1'b1;
                        fb_addr_r <= pix_addr(head.x, head.y, WIDTH);
                        fb_data_r <= head.color;
                    end else if (grant) begin
                        fb_we_r <= 1'b0;
                    end

                    if (state == IDLE && clear_start) begin
                        state <= FLUSH;
                    end else if (state == FLUSH && fifo_empty && !fb_we_r) begin
                        // First sweep write is presented the cycle CLEAR is entered.
                        state     <= CLEAR;
                        fb_we_r   <= 1'b1;
                        fb_addr_r <= '0;
                        fb_data_r <= 1'b0;
                    end
                end
                CLEAR: begin
                    if (grant) begin
                        if (fb_addr_r == LAST_ADDR) begin
                            fb_we_r <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            fb_addr_r <= fb_addr_r + ADDR_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
